// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking barrier controller and its display block.
// Holds the gate state encoding, direction constants and default lot size.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } gate_state_t;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    localparam int DEF_CAPACITY = 8;
    localparam int DEF_OCC_W    = 4;

endpackage

// File: rtl/parking_gate_ctrl_tick_edge_det.sv
// Registers a slow square wave (divider output treated as data) and flags its rising edge.
// Latency: level_q lags one cycle; rise is combinational off the live input. No backpressure.
module tick_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic wave,
    output logic level_q,
    output logic rise
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= wave;
        end
    end

    assign rise = wave & ~level_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier sequencer with occupancy tracking; timebase is the 1 Hz / 2 Hz divider output.
// Latency: one cycle request->busy, full lags occupancy by one cycle. Requests outside IDLE are ignored.
// Optional PARK_GATE_STATS_EN adds total_entries / total_timeouts counters.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY         = DEF_CAPACITY,
    parameter int OCC_W            = DEF_OCC_W,
    parameter int MOVE_SEC         = 1,
    parameter int OPEN_TIMEOUT_SEC = 10,
    parameter int TMR_W            = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_1Hz_in,
    input  logic             clk_2Hz_in,
    input  logic             enter_req,
    input  logic             exit_req,
    input  logic             pass_sensor,
    output logic             gate_open,
    output logic             dir_exit,
    output logic             warn_led,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic             busy,
    output logic             reject,
    output logic             timeout
`ifdef PARK_GATE_STATS_EN
    ,
    output logic [15:0]      total_entries,
    output logic [7:0]       total_timeouts
`endif
);

    gate_state_t      state;
    logic [TMR_W-1:0] timer;
    logic             moving;
    logic             sec_tick;
    logic             hz1_level;
    logic             hz2_level;
    logic             hz2_rise;
    logic             move_done;
    logic             pass_evt;
    logic             timeout_evt;
    logic             unused_ok;

    tick_edge_det u_tick_1hz (
        .clk     (clk),
        .reset   (reset),
        .wave    (clk_1Hz_in),
        .level_q (hz1_level),
        .rise    (sec_tick)
    );

    tick_edge_det u_tick_2hz (
        .clk     (clk),
        .reset   (reset),
        .wave    (clk_2Hz_in),
        .level_q (hz2_level),
        .rise    (hz2_rise)
    );

    assign unused_ok = &{1'b0, hz1_level, hz2_rise};

    // The tick that would bring the timer up to the limit is the one that ends the phase.
    assign move_done   = sec_tick && (timer == TMR_W'(MOVE_SEC - 1));
    assign pass_evt    = (state == OPEN) && pass_sensor;
    assign timeout_evt = (state == OPEN) && !pass_sensor && sec_tick
                         && (timer == TMR_W'(OPEN_TIMEOUT_SEC - 1));

    assign warn_led = moving & hz2_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            gate_open <= 1'b0;
            dir_exit  <= DIR_ENTRY;
            busy      <= 1'b0;
            moving    <= 1'b0;
            occupancy <= '0;
            full      <= 1'b0;
            reject    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            reject  <= 1'b0;
            timeout <= 1'b0;
            full    <= (occupancy == OCC_W'(CAPACITY));
            if (sec_tick) begin
                timer <= timer + TMR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (exit_req) begin
                        if (occupancy == '0) begin
                            reject <= 1'b1;
                        end else begin
                            dir_exit  <= DIR_EXIT;
                            state     <= OPENING;
                            timer     <= '0;
                            gate_open <= 1'b1;
                            busy      <= 1'b1;
                            moving    <= 1'b1;
                        end
                    end else if (enter_req) begin
                        if (full) begin
                            reject <= 1'b1;
                        end else begin
                            dir_exit  <= DIR_ENTRY;
                            state     <= OPENING;
                            timer     <= '0;
                            gate_open <= 1'b1;
                            busy      <= 1'b1;
                            moving    <= 1'b1;
                        end
                    end
                end
                OPENING: begin
                    if (move_done) begin
                        state  <= OPEN;
                        timer  <= '0;
                        moving <= 1'b0;
                    end
                end
                OPEN: begin
                    if (pass_evt || timeout_evt) begin
                        if (pass_evt) begin
                            occupancy <= (dir_exit == DIR_EXIT) ? occupancy - OCC_W'(1)
                                                                : occupancy + OCC_W'(1);
                        end else begin
                            timeout <= 1'b1;
                        end
                        state     <= CLOSING;
                        timer     <= '0;
                        gate_open <= 1'b0;
                        moving    <= 1'b1;
                    end
                end
                CLOSING: begin
                    if (move_done) begin
                        state  <= IDLE;
                        timer  <= '0;
                        busy   <= 1'b0;
                        moving <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PARK_GATE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_entries  <= '0;
            total_timeouts <= '0;
        end else begin
            if (pass_evt && (dir_exit == DIR_ENTRY)) begin
                total_entries <= total_entries + 16'd1;
            end
            if (timeout_evt && (total_timeouts != 8'hFF)) begin
                total_timeouts <= total_timeouts + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: constant vector table, directed corner sequences,
// and randomized traffic compared each cycle against a transaction-level lot model.
module tb_parking_gate_ctrl;

    localparam int CAP = 8;
    localparam int MOVE = 1;
    localparam int TMO = 10;

    logic       clk;
    logic       reset;
    logic       clk_1Hz_in;
    logic       clk_2Hz_in;
    logic       enter_req;
    logic       exit_req;
    logic       pass_sensor;
    logic       gate_open;
    logic       dir_exit;
    logic       warn_led;
    logic [3:0] occupancy;
    logic       full;
    logic       busy;
    logic       reject;
    logic       timeout;
`ifdef PARK_GATE_STATS_EN
    logic [15:0] total_entries;
    logic [7:0]  total_timeouts;
`endif

    parking_gate_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .clk_1Hz_in  (clk_1Hz_in),
        .clk_2Hz_in  (clk_2Hz_in),
        .enter_req   (enter_req),
        .exit_req    (exit_req),
        .pass_sensor (pass_sensor),
        .gate_open   (gate_open),
        .dir_exit    (dir_exit),
        .warn_led    (warn_led),
        .occupancy   (occupancy),
        .full        (full),
        .busy        (busy),
        .reject      (reject),
        .timeout     (timeout)
`ifdef PARK_GATE_STATS_EN
        ,
        .total_entries  (total_entries),
        .total_timeouts (total_timeouts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Lot model: phase 0 waiting, 1 barrier rising, 2 barrier up, 3 barrier lowering.
    int   m_phase, m_secs, m_occ, m_entries, m_touts;
    logic m_full, m_dir, m_rej, m_to, m_prev1, m_prev2;

    task automatic model_reset();
        m_phase = 0; m_secs = 0; m_occ = 0; m_entries = 0; m_touts = 0;
        m_full = 0; m_dir = 0; m_rej = 0; m_to = 0; m_prev1 = 0; m_prev2 = 0;
    endtask

    task automatic model_update(input logic hz1, input logic hz2);
        logic tick, nfull;
        tick  = hz1 & ~m_prev1;
        nfull = (m_occ == CAP);
        m_rej = 0;
        m_to  = 0;
        case (m_phase)
            0: begin
                if (exit_req) begin
                    if (m_occ == 0) m_rej = 1;
                    else begin m_dir = 1; m_phase = 1; m_secs = 0; end
                end else if (enter_req) begin
                    if (m_full) m_rej = 1;
                    else begin m_dir = 0; m_phase = 1; m_secs = 0; end
                end
            end
            1, 3: begin
                if (tick) begin
                    m_secs++;
                    if (m_secs >= MOVE) begin
                        m_phase = (m_phase == 1) ? 2 : 0;
                        m_secs  = 0;
                    end
                end
            end
            default: begin
                if (pass_sensor) begin
                    if (m_dir) m_occ--;
                    else begin m_occ++; m_entries = (m_entries + 1) % 65536; end
                    m_phase = 3; m_secs = 0;
                end else if (tick) begin
                    m_secs++;
                    if (m_secs >= TMO) begin
                        m_to = 1;
                        if (m_touts < 255) m_touts++;
                        m_phase = 3; m_secs = 0;
                    end
                end
            end
        endcase
        m_full  = nfull;
        m_prev1 = hz1;
        m_prev2 = hz2;
    endtask

    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        v = '0;
        v[10:0] = {(m_phase == 1 || m_phase == 2), m_dir, (m_phase == 1 || m_phase == 3) & m_prev2,
                   4'(m_occ), m_full, (m_phase != 0), m_rej, m_to};
`ifdef PARK_GATE_STATS_EN
        v[34:11] = {16'(m_entries), 8'(m_touts)};
`endif
        return v;
    endfunction

    function automatic logic [63:0] dut_vec();
        logic [63:0] v;
        v = '0;
        v[10:0] = {gate_open, dir_exit, warn_led, occupancy, full, busy, reject, timeout};
`ifdef PARK_GATE_STATS_EN
        v[34:11] = {total_entries, total_timeouts};
`endif
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Called at a falling edge: drive the timebase, clock once, compare against the model.
    task automatic step();
        logic hz1, hz2;
        hz1 = ((cyc / 10) % 2) == 1;
        hz2 = ((cyc / 5) % 2) == 1;
        clk_1Hz_in = hz1;
        clk_2Hz_in = hz2;
        @(posedge clk);
        if (!reset) model_reset();
        else model_update(hz1, hz2);
        cyc++;
        @(negedge clk);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while (m_phase != ph && k < 400) begin
            step();
            k++;
        end
        if (m_phase != ph) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_phase: model phase %0d, required %0d", m_phase, ph);
        end
    endtask

    task automatic do_txn(input bit is_exit, input bit do_pass);
        if (is_exit) exit_req = 1; else enter_req = 1;
        step();
        exit_req = 0;
        enter_req = 0;
        if (do_pass) begin
            wait_phase(2);
            pass_sensor = 1;
            step();
            pass_sensor = 0;
        end
        wait_phase(0);
    endtask

    typedef struct {
        logic en;
        logic ex;
        logic ps;
        int   n;
        logic gate;
        logic bsy;
        int   occ;
        logic ful;
        logic rej;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int tcount, k;
        // Ticks land on steps 10, 30, 50...; rows are checked after their last cycle.
        tbl[0] = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1,  0, 0, 0, 0, 1};
        tbl[2] = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[3] = '{1, 0, 0, 1,  1, 1, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 6,  1, 1, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 1,  1, 1, 0, 0, 0};
        tbl[6] = '{0, 0, 1, 1,  0, 1, 1, 0, 0};
        tbl[7] = '{0, 0, 0, 18, 0, 1, 1, 0, 0};
        tbl[8] = '{0, 0, 0, 1,  0, 0, 1, 0, 0};

        reset = 0; enter_req = 0; exit_req = 0; pass_sensor = 0;
        clk_1Hz_in = 0; clk_2Hz_in = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", dut_vec(), 64'd0);
        reset = 1;

        for (int i = 0; i < 9; i++) begin
            enter_req = tbl[i].en;
            exit_req = tbl[i].ex;
            pass_sensor = tbl[i].ps;
            for (int j = 0; j < tbl[i].n; j++) step();
            check($sformatf("table_row%0d", i), {gate_open, busy, occupancy, full, reject},
                  {tbl[i].gate, tbl[i].bsy, 4'(tbl[i].occ), tbl[i].ful, tbl[i].rej});
        end
        enter_req = 0; exit_req = 0; pass_sensor = 0;

        for (int i = 0; i < 7; i++) do_txn(0, 1);
        repeat (2) step();
        check("fill_occ_full", {occupancy, full}, {4'd8, 1'b1});

        enter_req = 1;
        step();
        enter_req = 0;
        check("full_reject", {reject, busy, full}, 3'b101);
        step();
        check("full_reject_pulse_end", {reject, busy}, 2'b00);

        do_txn(1, 1);
        check("exit_after_full", {occupancy, full}, {4'd7, 1'b0});

        enter_req = 1;
        step();
        enter_req = 0;
        tcount = 0;
        k = 0;
        while (m_phase != 0 && k < 400) begin
            step();
            if (timeout) tcount++;
            k++;
        end
        check("timeout_pulses", 64'(tcount), 64'd1);
        check("timeout_occ", {busy, occupancy}, {1'b0, 4'd7});

        for (int i = 0; i < 4; i++) do_txn(1, 1);
        check("occ_three", 64'(occupancy), 64'd3);
        enter_req = 1;
        exit_req = 1;
        step();
        enter_req = 0;
        exit_req = 0;
        check("exit_priority", {dir_exit, busy, reject}, 3'b110);
        wait_phase(2);
        pass_sensor = 1;
        step();
        pass_sensor = 0;
        wait_phase(0);
        check("exit_priority_occ", 64'(occupancy), 64'd2);

        enter_req = 1;
        step();
        enter_req = 0;
        wait_phase(2);
        k = 0;
        while (!(m_phase == 2 && m_secs == TMO - 1 && (cyc % 20) == 10) && k < 400) begin
            step();
            k++;
        end
        pass_sensor = 1;
        step();
        pass_sensor = 0;
        check("pass_beats_timeout", {timeout, gate_open, occupancy}, {1'b0, 1'b0, 4'd3});
        wait_phase(0);

        do_txn(0, 1);
        do_txn(0, 1);
        enter_req = 1;
        step();
        enter_req = 0;
        wait_phase(2);
        check("pre_reset_open", {gate_open, occupancy}, {1'b1, 4'd5});
        #2 reset = 0;
        #1;
        check("async_reset_outputs", {gate_open, warn_led, busy, occupancy}, 7'd0);
`ifdef PARK_GATE_STATS_EN
        check("async_reset_entries", 64'(total_entries), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        step();
        reset = 1;

        for (int i = 0; i < 3000; i++) begin
            enter_req = ($urandom % 8) == 0;
            exit_req = ($urandom % 10) == 0;
            pass_sensor = ($urandom % 6) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
